// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
//  Module   : rob_param
//  Purpose  : Parametrised reorder buffer. Issue allocates tagged entries at
//             the tail in program order. The CDB writes results by tag.
//             Entries retire in order from the head, with a commit handshake.
//             A mispredicted branch commit flushes the whole buffer.
//  Revision : 1.0  initial release
// ============================================================================
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              rst_n,
    // issue / allocate
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_op,
    input  logic [REG_AW-1:0] alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    // common data bus writeback
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispredict,
    // operand lookup
    input  logic [TAG_W-1:0]  q0_tag,
    input  logic [TAG_W-1:0]  q1_tag,
    output logic              q0_ready,
    output logic [DATA_W-1:0] q0_data,
    output logic              q1_ready,
    output logic [DATA_W-1:0] q1_data,
    // commit
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [3:0]        commit_op,
    output logic [REG_AW-1:0] commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_we,
    output logic              flush,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0]   c_DEPTH   = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   c_CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] c_TAG_ONE = TAG_W'(1);
    // Highest opcode that writes the register bank (add..load).
    localparam logic [3:0]       c_OP_LAST_WR = 4'b0100;

    // Entry storage
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_misp;
    logic [3:0]        r_op   [DEPTH];
    logic [REG_AW-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    // Pointers and occupancy (count separates full from empty)
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic w_head_done;
    logic w_head_misp;
    logic w_fire;
    logic w_flush;
    logic w_alloc_ok;
    logic w_alloc_fire;
    logic w_wb_hit;

    assign w_head_done  = r_valid[r_head] & r_done[r_head];
    assign w_head_misp  = r_misp[r_head];
    assign w_fire       = w_head_done & commit_ready;
    assign w_flush      = w_fire & w_head_misp;
    // A mispredicted head blocks issue so nothing is allocated into a squash.
    assign w_alloc_ok   = (r_count < c_DEPTH) & ~(w_head_done & w_head_misp);
    assign w_alloc_fire = alloc_valid & w_alloc_ok;
    assign w_wb_hit     = wb_valid & r_valid[wb_tag] & ~r_done[wb_tag];

    assign alloc_ready  = w_alloc_ok;
    assign alloc_tag    = r_tail;
    assign commit_valid = w_head_done;
    assign flush        = w_flush;
    assign count        = r_count;

    // Commit fields show the head entry only while it is ready to retire.
    assign commit_op    = w_head_done ? r_op[r_head]   : 4'b0000;
    assign commit_rd    = w_head_done ? r_rd[r_head]   : '0;
    assign commit_data  = w_head_done ? r_data[r_head] : '0;
    assign commit_we    = w_head_done & ~r_op[r_head][3] & (r_op[r_head] <= c_OP_LAST_WR);

    // Operand lookup 0: CDB bypass first, then stored result.
    always_comb begin
        q0_ready = 1'b0;
        q0_data  = '0;
        if (wb_valid && (wb_tag == q0_tag) && r_valid[q0_tag]) begin
            q0_ready = 1'b1;
            q0_data  = wb_data;
        end else if (r_valid[q0_tag] && r_done[q0_tag]) begin
            q0_ready = 1'b1;
            q0_data  = r_data[q0_tag];
        end
    end

    // Operand lookup 1: CDB bypass first, then stored result.
    always_comb begin
        q1_ready = 1'b0;
        q1_data  = '0;
        if (wb_valid && (wb_tag == q1_tag) && r_valid[q1_tag]) begin
            q1_ready = 1'b1;
            q1_data  = wb_data;
        end else if (r_valid[q1_tag] && r_done[q1_tag]) begin
            q1_ready = 1'b1;
            q1_data  = r_data[q1_tag];
        end
    end

    // Head/tail pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clk1) begin
        if (!rst_n || w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + c_TAG_ONE;
            end
            if (w_fire) begin
                r_head <= r_head + c_TAG_ONE;
            end
            case ({w_alloc_fire, w_fire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry array: allocate at tail, writeback by tag, retire at head.
    // The three targets never coincide: the tail slot is free whenever an
    // allocate fires, and a done head ignores writebacks.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
            r_misp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= 4'b0000;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (w_flush) begin
            // Same-cycle writeback is discarded along with every entry.
            r_valid <= '0;
            r_done  <= '0;
            r_misp  <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_misp[r_tail]  <= 1'b0;
                r_op[r_tail]    <= alloc_op;
                r_rd[r_tail]    <= alloc_rd;
                r_data[r_tail]  <= '0;
            end
            if (w_wb_hit) begin
                r_done[wb_tag]  <= 1'b1;
                r_misp[wb_tag]  <= wb_mispredict;
                r_data[wb_tag]  <= wb_data;
            end
            if (w_fire) begin
                r_valid[r_head] <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
